// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with valid/ready and optional skid
//
// Purpose: carries control, payload, PC+4 and instruction between two MIPS
// pipeline stages. Supports valid/ready handshaking, an optional 2-entry skid
// buffer (main register M + skid register S), flush-to-bubble and optional
// gating of control bits on empty slots.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      discard all held entries this cycle
//   in_valid / in_ready        upstream handshake
//   in_ctrl/data/pc/inst       upstream entry fields
//   out_valid / out_ready      downstream handshake
//   out_ctrl/data/pc/inst      registered entry fields (M)
module pipe_stage_reg #(
  parameter int                CTRL_W    = 6,
  parameter int                DATA_W    = 69,
  parameter int                PC_W      = 32,
  parameter int                INST_W    = 32,
  parameter logic [INST_W-1:0] NOP       = INST_W'(32'h0000_0020),
  parameter int                SKID      = 1,
  parameter int                CTRL_GATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [PC_W-1:0]   m_pc;
  logic [INST_W-1:0] m_inst;

  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic [PC_W-1:0]   s_pc;
  logic [INST_W-1:0] s_inst;

  logic in_ready_q;
  logic in_xfer;
  logic m_load;
  logic s_valid_nxt;

  // With the skid buffer in_ready is a flop; without it the stage can only
  // take a new entry when M is empty or being drained this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0) begin
      in_ready = in_ready_q;
    end else begin
      in_ready = !m_valid | out_ready;
    end
  end

  assign in_xfer = in_valid & in_ready;
  assign m_load  = !m_valid | out_ready;

  // S empties whenever M reloads (from S first); it fills only when an entry
  // arrives while M is stalled. in_ready next cycle is simply "S will be empty".
  always_comb begin
    s_valid_nxt = 1'b0;
    if (!m_load) begin
      s_valid_nxt = s_valid | (in_xfer && (SKID != 0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_ctrl     <= '0;
      m_data     <= '0;
      m_pc       <= '0;
      m_inst     <= NOP;
      s_valid    <= 1'b0;
      s_ctrl     <= '0;
      s_data     <= '0;
      s_pc       <= '0;
      s_inst     <= NOP;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // PC survives the flush so the redirect target stays observable.
      m_valid    <= 1'b0;
      m_ctrl     <= '0;
      m_data     <= '0;
      m_pc       <= in_pc;
      m_inst     <= NOP;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (m_load) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_ctrl  <= s_ctrl;
          m_data  <= s_data;
          m_pc    <= s_pc;
          m_inst  <= s_inst;
          s_valid <= 1'b0;
        end else if (in_xfer) begin
          m_valid <= 1'b1;
          m_ctrl  <= in_ctrl;
          m_data  <= in_data;
          m_pc    <= in_pc;
          m_inst  <= in_inst;
        end else begin
          // Bubble: data and PC keep their last value, instruction becomes NOP.
          m_valid <= 1'b0;
          m_inst  <= NOP;
          if (CTRL_GATE != 0) begin
            m_ctrl <= '0;
          end
        end
      end else if (in_xfer && (SKID != 0)) begin
        s_valid <= 1'b1;
        s_ctrl  <= in_ctrl;
        s_data  <= in_data;
        s_pc    <= in_pc;
        s_inst  <= in_inst;
      end
      in_ready_q <= !s_valid_nxt;
    end
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign out_pc    = m_pc;
  assign out_inst  = m_inst;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (skid and non-skid variants)
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [5:0]  in_ctrl;
  logic [68:0] in_data;
  logic [31:0] in_pc, in_inst;

  logic        r1_in_ready, r1_valid;
  logic [5:0]  r1_ctrl;
  logic [68:0] r1_data;
  logic [31:0] r1_pc, r1_inst;

  logic        r0_in_ready, r0_valid;
  logic [5:0]  r0_ctrl;
  logic [68:0] r0_data;
  logic [31:0] r0_pc, r0_inst;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1), .CTRL_GATE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r1_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(r1_valid), .out_ready(out_ready),
    .out_ctrl(r1_ctrl), .out_data(r1_data), .out_pc(r1_pc), .out_inst(r1_inst)
  );

  pipe_stage_reg #(.SKID(0), .CTRL_GATE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r0_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(r0_valid), .out_ready(out_ready),
    .out_ctrl(r0_ctrl), .out_data(r0_data), .out_pc(r0_pc), .out_inst(r0_inst)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: each instance is a FIFO of held entries (skid: up to 2,
  // plain: up to 1). Index 1 = skid/gated instance, index 0 = plain/ungated.
  typedef struct packed {
    logic [5:0]  c;
    logic [68:0] d;
    logic [31:0] p;
    logic [31:0] i;
  } ent_t;

  ent_t mq [2][2];
  int   mn [2];
  ent_t last [2];
  bit   started = 1'b0;

  function automatic bit mrdy(int k);
    if (k == 1) return mn[1] < 2;
    return (mn[0] == 0) || out_ready;
  endfunction

  function automatic ent_t exp_out(int k);
    ent_t e;
    if (mn[k] > 0) return mq[k][0];
    e = last[k];
    e.i = NOP;
    if (k == 1) e.c = '0;
    return e;
  endfunction

  always @(posedge clk) begin
    bit   rdy [2];
    ent_t cur;
    cur = '{c: in_ctrl, d: in_data, p: in_pc, i: in_inst};
    for (int k = 0; k < 2; k++) rdy[k] = mrdy(k);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mn[k]   = 0;
        last[k] = '0;
      end else if (flush) begin
        mn[k]     = 0;
        last[k]   = '0;
        last[k].p = in_pc;
      end else begin
        if (out_ready && mn[k] > 0) begin
          mq[k][0] = mq[k][1];
          mn[k]    = mn[k] - 1;
        end
        if (in_valid && rdy[k]) begin
          mq[k][mn[k]] = cur;
          mn[k]        = mn[k] + 1;
        end
      end
      if (mn[k] > 0) last[k] = mq[k][0];
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    ent_t e1, e0;
    if (started) begin
      e1 = exp_out(1);
      e0 = exp_out(0);
      check("d1_in_ready", r1_in_ready, mrdy(1));
      check("d1_valid",    r1_valid,    mn[1] > 0);
      check("d1_ctrl",     r1_ctrl,     e1.c);
      check("d1_data",     r1_data,     e1.d);
      check("d1_pc",       r1_pc,       e1.p);
      check("d1_inst",     r1_inst,     e1.i);
      check("d0_in_ready", r0_in_ready, mrdy(0));
      check("d0_valid",    r0_valid,    mn[0] > 0);
      check("d0_ctrl",     r0_ctrl,     e0.c);
      check("d0_data",     r0_data,     e0.d);
      check("d0_pc",       r0_pc,       e0.p);
      check("d0_inst",     r0_inst,     e0.i);
    end
  end

  task automatic set_entry(input logic [31:0] p);
    in_pc   = p;
    in_ctrl = p[7:2] ^ 6'h2A;
    in_data = {p, ~p, p[4:0]};
    in_inst = {16'hABCD, p[15:0]};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    set_entry(32'h0);

    // Reset held for two cycles with random traffic offered.
    for (int n = 0; n < 2; n++) begin
      in_ctrl = 6'($urandom); in_data = {37'($urandom), 32'($urandom)};
      in_pc = $urandom; in_inst = $urandom; out_ready = 1'($urandom);
      tick();
    end
    check("rst_valid", r1_valid, 1'b0);
    check("rst_ctrl",  r1_ctrl,  6'h0);
    check("rst_data",  r1_data,  69'h0);
    check("rst_pc",    r1_pc,    32'h0);
    check("rst_inst",  r1_inst,  32'h20);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("rst_in_ready_skid",  r1_in_ready, 1'b1);
    check("rst_in_ready_plain", r0_in_ready, 1'b1);

    // Streaming at full rate.
    for (int n = 1; n <= 8; n++) begin
      in_valid = 1'b1;
      set_entry(32'(4 * n));
      tick();
      check("stream_pc",       r1_pc,       32'(4 * n));
      check("stream_valid",    r1_valid,    1'b1);
      check("stream_in_ready", r1_in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", r1_valid, 1'b0);
    check("stream_end_inst",  r1_inst,  32'h20);

    // Backpressure: A held, B in skid, C refused until space.
    out_ready = 1'b0; in_valid = 1'b1;
    set_entry(32'h100); tick();
    check("bp_a_pc", r1_pc, 32'h100);
    set_entry(32'h104); tick();
    check("bp_hold_a_pc", r1_pc, 32'h100);
    check("bp_two_ready", r1_in_ready, 1'b0);
    set_entry(32'h108); tick();
    check("bp_c_refused_pc", r1_pc, 32'h100);
    check("bp_c_refused_ready", r1_in_ready, 1'b0);
    out_ready = 1'b1; tick();
    check("bp_b_pc", r1_pc, 32'h104);
    tick();
    check("bp_c_pc", r1_pc, 32'h108);
    check("bp_c_inst", r1_inst, 32'hABCD_0108);
    in_valid = 1'b0; tick();
    check("bp_drained", r1_valid, 1'b0);

    // Flush while two entries are held.
    out_ready = 1'b0; in_valid = 1'b1;
    set_entry(32'h300); tick();
    set_entry(32'h304); tick();
    flush = 1'b1; set_entry(32'h200); tick();
    check("fl_valid",    r1_valid,    1'b0);
    check("fl_inst",     r1_inst,     32'h20);
    check("fl_ctrl",     r1_ctrl,     6'h0);
    check("fl_data",     r1_data,     69'h0);
    check("fl_pc",       r1_pc,       32'h200);
    check("fl_in_ready", r1_in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("fl_nothing_emerges", r1_valid, 1'b0);

    // Reset in the middle of a stalled, full stage.
    out_ready = 1'b0; in_valid = 1'b1;
    set_entry(32'h400); tick();
    set_entry(32'h404); tick();
    rst = 1'b1; tick();
    check("mrst_valid", r1_valid, 1'b0);
    check("mrst_pc",    r1_pc,    32'h0);
    check("mrst_inst",  r1_inst,  32'h20);
    rst = 1'b0; out_ready = 1'b1; set_entry(32'h500); tick();
    check("mrst_d_pc",    r1_pc,    32'h500);
    check("mrst_d_valid", r1_valid, 1'b1);
    in_valid = 1'b0; tick();

    // Plain register, ungated control.
    out_ready = 1'b0; in_valid = 1'b1;
    set_entry(32'h600); tick();
    check("p_valid",       r0_valid,    1'b1);
    check("p_stall_ready", r0_in_ready, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("p_comb_ready", r0_in_ready, 1'b1);
    tick();
    check("p_drain_valid", r0_valid, 1'b0);
    check("p_ctrl_kept",   r0_ctrl,  6'h2A);
    check("p_inst_nop",    r0_inst,  32'h20);
    check("g_ctrl_gated",  r1_ctrl,  6'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core. It is the successor to the fixed-width per-stage latches. It carries a control bundle, a data payload, PC+4 and the instruction word. It adds a valid/ready handshake, an optional 2-entry skid buffer for full-throughput backpressure, flush-to-bubble, and optional masking of control bits on invalid slots. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB), sized by parameters.

Parameters:
CTRL_W, 6, width of control bundle (memread, memwrite, regwrite, ...); all-zero means no side effects.
DATA_W, 69, payload width (e.g. data 32 + address 32 + wraddr 5).
PC_W, 32, width of PC+4 field.
INST_W, 32, width of instruction field.
NOP, 32'h0000_0020, instruction value inserted on bubble/reset.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CTRL_GATE, 1, 1 = out_ctrl forced to 0 whenever out_valid=0.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  discard all held entries this cycle.
in_valid  in  1  upstream entry present.
in_ready  out  1  stage can accept this cycle.
in_ctrl  in  CTRL_W  upstream control bundle.
in_data  in  DATA_W  upstream payload.
in_pc  in  PC_W  upstream PC+4.
in_inst  in  INST_W  upstream instruction.
out_valid  out  1  downstream entry present.
out_ready  in  1  downstream accepts this cycle.
out_ctrl  out  CTRL_W  registered control.
out_data  out  DATA_W  registered payload.
out_pc  out  PC_W  registered PC+4.
out_inst  out  INST_W  registered instruction.

Behaviour:
- Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. Outputs are driven only from registers.
- Reset (rst=1 at an edge, including mid-transfer): out_valid=0, out_ctrl=0, out_data=0, out_pc=0, out_inst=NOP. Skid is emptied. in_ready=1 from the first cycle after reset (SKID=1).
- Latency: an accepted entry appears on the out_* ports 1 cycle after the accept edge.
- SKID=1 datapath: main register M plus skid register S (state EMPTY / ONE = M valid / TWO = M and S valid).
  - M loads when it is empty or an output transfer occurs. It loads from S if S is valid, else from the input if an input transfer occurs. Otherwise it becomes invalid.
  - If an input is accepted while M is valid and out_ready=0, the entry goes into S.
  - in_ready is registered as !S_valid_next. It is never 1 in state TWO.
  - Order is strictly FIFO. No entry is dropped or duplicated.
- SKID=0: in_ready = !out_valid | out_ready (combinational). M loads on an input transfer. M is cleared to invalid on an output transfer without an input transfer. M holds while out_valid & !out_ready.
- Flush (takes priority over any transfer, below rst):
  - M and S are invalidated.
  - out_ctrl=0, out_data=0, out_inst=NOP, out_pc=in_pc (PC preserved for the exception/branch target).
  - An input offered in the flush cycle is consumed and discarded. in_ready may be 1, but the entry does not appear.
  - In SKID=1, in_ready=1 the cycle after a flush.
- Invalid slots: when out_valid=0, out_inst=NOP. out_ctrl=0 if CTRL_GATE=1; if CTRL_GATE=0, out_ctrl holds its last value.
- Hold: while out_valid=1 and out_ready=0, every out_* field is stable (no glitch, no update).
- Simultaneous in and out transfers in state ONE: M replaces its content. State stays ONE. Throughput is 1 per cycle.
- Simultaneous in and out transfers in state TWO: not possible, because in_ready=0.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1 and random inputs -> out_valid=0, out_ctrl=0, out_data=0, out_pc=0, out_inst=32'h20; in_ready=1 after release.
2. Streaming: out_ready=1, send 8 back-to-back entries with pc=4,8,...,32 -> each appears 1 cycle later, out_valid continuous, in_ready never drops.
3. Backpressure (SKID=1): out_ready=0, offer A (pc=0x100), B (0x104), C (0x108) -> A held on the outputs, B in skid, in_ready=0, C not accepted. Raise out_ready -> A, B, C emerge in order, none lost or duplicated.
4. Flush while TWO, with in_valid=1 and in_pc=0x200 -> next cycle out_valid=0, out_inst=32'h20, out_ctrl=0, out_pc=0x200, in_ready=1. Neither held entry nor the offered entry ever appears.
5. Mid-stream reset: assert rst while state TWO and out_ready=0 -> all reset values next cycle; subsequent entry D passes normally with latency 1.
6. SKID=0, CTRL_GATE=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally. After drain with no input, out_ctrl keeps its last value and out_inst=32'h20.
